// File: rtl/avalon_pio_pkg.sv
// Shared register map for the Avalon PIO/PWM slave.
package avalon_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_TOG    = 3'd3;
  localparam logic [2:0] ADDR_MODE   = 3'd4;
  localparam logic [2:0] ADDR_PERIOD = 3'd5;
  localparam logic [2:0] ADDR_DUTY   = 3'd6;
  localparam logic [2:0] ADDR_STATUS = 3'd7;

  localparam int STATUS_PHASE_BIT = 31;

endpackage

// File: rtl/pio_pwm_timebase.sv
// Blink prescaler with phase flag, plus a free-running PWM counter and compare.
module pio_pwm_timebase
  import avalon_pio_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int PRESC_BITS = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRESC_BITS-1:0] period,
  input  logic                  period_wr,
  input  logic [PWM_BITS-1:0]   duty,
  output logic                  blink_phase,
  output logic                  pwm_on
);

  logic [PRESC_BITS-1:0] presc_cnt;
  logic [PWM_BITS-1:0]   pwm_cnt;

  // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt   <= '0;
      blink_phase <= 1'b0;
      pwm_cnt     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      // A new period restarts the half-period count but keeps the current phase.
      if (period_wr || period == '0) begin
        presc_cnt <= '0;
      end else if (presc_cnt == period - PRESC_BITS'(1)) begin
        presc_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        presc_cnt <= presc_cnt + PRESC_BITS'(1);
      end
    end
  end

  // Full-scale duty must be solid on; a plain compare would drop one count.
  assign pwm_on = (duty == '1) || (pwm_cnt < duty);

endmodule

// File: rtl/avalon_pio_pwm.sv
// Avalon-MM PIO with atomic set/clear/toggle, per-channel blink and global PWM dimming.
module avalon_pio_pwm
  import avalon_pio_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int PWM_BITS       = 8,
  parameter int PRESC_BITS     = 24,
  parameter int DEFAULT_PERIOD = 12500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic [WIDTH-1:0] pio_out
);

  logic [WIDTH-1:0]      data_q;
  logic [WIDTH-1:0]      mode_q;
  logic [PRESC_BITS-1:0] period_q;
  logic [PWM_BITS-1:0]   duty_q;
  logic [WIDTH-1:0]      wd_ch;
  logic [WIDTH-1:0]      raw;
  logic [31:0]           rd_mux;
  logic [31:0]           unused_wd;
  logic                  period_wr;
  logic                  blink_phase;
  logic                  pwm_on;

  assign wd_ch     = avs_writedata[WIDTH-1:0];
  assign unused_wd = avs_writedata;
  assign period_wr = avs_write && (avs_address == ADDR_PERIOD);

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      mode_q   <= '0;
      period_q <= PRESC_BITS'(DEFAULT_PERIOD);
      duty_q   <= '1;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_DATA:   data_q   <= wd_ch;
        ADDR_SET:    data_q   <= data_q | wd_ch;
        ADDR_CLR:    data_q   <= data_q & ~wd_ch;
        ADDR_TOG:    data_q   <= data_q ^ wd_ch;
        ADDR_MODE:   mode_q   <= wd_ch;
        ADDR_PERIOD: period_q <= avs_writedata[PRESC_BITS-1:0];
        ADDR_DUTY:   duty_q   <= avs_writedata[PWM_BITS-1:0];
        default:     ;
      endcase
    end
  end

  pio_pwm_timebase #(
    .PWM_BITS   (PWM_BITS),
    .PRESC_BITS (PRESC_BITS)
  ) u_timebase (
    .clk         (clk),
    .reset       (reset),
    .period      (period_q),
    .period_wr   (period_wr),
    .duty        (duty_q),
    .blink_phase (blink_phase),
    .pwm_on      (pwm_on)
  );

  // NOTE: rd_mux gets a default first so no path through the case can infer a latch.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA, ADDR_SET, ADDR_CLR, ADDR_TOG: rd_mux = 32'(data_q);
      ADDR_MODE:   rd_mux = 32'(mode_q);
      ADDR_PERIOD: rd_mux = 32'(period_q);
      ADDR_DUTY:   rd_mux = 32'(duty_q);
      ADDR_STATUS: begin
        rd_mux                   = 32'(pio_out);
        rd_mux[STATUS_PHASE_BIT] = blink_phase;
      end
      default:     rd_mux = '0;
    endcase
  end

  // Blinking channels are gated by the phase; every channel is gated by the PWM.
  assign raw = data_q & ((mode_q & {WIDTH{blink_phase}}) | ~mode_q) & {WIDTH{pwm_on}};

  // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      avs_readdata <= '0;
      pio_out      <= '0;
    end else begin
      pio_out <= raw;
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_avalon_pio_pwm.sv
// Randomised scoreboard bench for avalon_pio_pwm against a time-based reference model.
module tb_avalon_pio_pwm;

  localparam int W    = 8;
  localparam int PB   = 8;
  localparam int PRB  = 24;
  localparam int DEFP = 12500000;

  logic          clk;
  logic          reset;
  logic [2:0]    avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic [W-1:0]  pio_out;

  avalon_pio_pwm #(
    .WIDTH          (W),
    .PWM_BITS       (PB),
    .PRESC_BITS     (PRB),
    .DEFAULT_PERIOD (DEFP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .pio_out       (pio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd_q[$];
  logic [31:0] pio_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase is derived from elapsed time since the last anchor
  // (reset or PERIOD write or frozen period), PWM count from time since reset.
  logic [W-1:0]   m_data, m_mode, m_pio;
  logic [PRB-1:0] m_period;
  logic [PB-1:0]  m_duty;
  logic           m_phase, anchor_ph;
  int unsigned    t, anchor_t;

  task automatic model_step();
    logic [31:0]  rdv;
    logic         ph_pre;
    logic         on;
    logic [W-1:0] raw;
    logic [W-1:0] wd;
    if (reset) begin
      m_data = '0; m_mode = '0; m_period = PRB'(DEFP); m_duty = '1;
      t = 0; anchor_t = 0; anchor_ph = 1'b0; m_phase = 1'b0; m_pio = '0;
      pio_q.push_back(32'd0);
      if (avs_read) rd_q.push_back(32'd0);
      return;
    end
    ph_pre = m_phase;
    if (avs_read) begin
      case (avs_address)
        3'd0, 3'd1, 3'd2, 3'd3: rdv = 32'(m_data);
        3'd4:    rdv = 32'(m_mode);
        3'd5:    rdv = 32'(m_period);
        3'd6:    rdv = 32'(m_duty);
        default: begin rdv = 32'(m_pio); rdv[31] = ph_pre; end
      endcase
      rd_q.push_back(rdv);
    end
    on = (m_duty == 8'hFF) || ((t % 256) < m_duty);
    for (int i = 0; i < W; i++)
      raw[i] = m_data[i] && (m_mode[i] ? ph_pre : 1'b1) && on;
    m_pio = raw;
    pio_q.push_back(32'(raw));
    t++;
    if (avs_write) begin
      wd = avs_writedata[W-1:0];
      case (avs_address)
        3'd0: m_data = wd;
        3'd1: m_data = m_data | wd;
        3'd2: m_data = m_data & ~wd;
        3'd3: m_data = m_data ^ wd;
        3'd4: m_mode = wd;
        3'd5: begin m_period = avs_writedata[PRB-1:0]; anchor_t = t; anchor_ph = ph_pre; end
        3'd6: m_duty = avs_writedata[PB-1:0];
        default: ;
      endcase
    end
    if (m_period == 0) begin
      anchor_t = t; anchor_ph = ph_pre; m_phase = ph_pre;
    end else begin
      m_phase = anchor_ph ^ ((((t - anchor_t) / m_period) % 2) == 1);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: readdata is valid the cycle after a read, pio_out every cycle.
  initial forever begin
    @(negedge clk);
    if (pio_q.size() > 0) check("pio_out", 32'(pio_out), pio_q.pop_front());
    if (rd_q.size() > 0)  check("readdata", avs_readdata, rd_q.pop_front());
  end

  task automatic bus(input logic [2:0] a, input logic r, input logic w, input logic [31:0] d);
    avs_address = a; avs_read = r; avs_write = w; avs_writedata = d;
    @(posedge clk);
    #1;
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus(a, 1'b0, 1'b1, d);
  endtask

  task automatic rd(input logic [2:0] a);
    bus(a, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    idle(2);
    reset = 1'b0;

    // Reset values
    rd(3'd0); rd(3'd4); rd(3'd5); rd(3'd6); rd(3'd7);

    // Atomic set/clear/toggle
    wr(3'd0, 32'hA5); rd(3'd0);
    wr(3'd1, 32'h0F); rd(3'd1);
    wr(3'd2, 32'h81); rd(3'd2);
    wr(3'd3, 32'hFF); rd(3'd3); rd(3'd0);

    // Blink channel 0 with half-period 4
    wr(3'd0, 32'hFF); wr(3'd4, 32'h01); wr(3'd5, 32'd4);
    for (int i = 0; i < 12; i++) rd(3'd7);

    // Freeze then restart with period 3
    wr(3'd5, 32'd0); idle(6); rd(3'd7);
    wr(3'd5, 32'd3);
    for (int i = 0; i < 8; i++) rd(3'd7);

    // PWM brightness: 64/256, off, full
    wr(3'd4, 32'h00); wr(3'd0, 32'h01); wr(3'd6, 32'd64); idle(520);
    wr(3'd6, 32'd0);  idle(260);
    wr(3'd6, 32'hFF); idle(260);

    // Reset in the middle of blinking
    wr(3'd0, 32'hFF); wr(3'd4, 32'hF0); wr(3'd5, 32'd2); idle(7);
    reset = 1'b1; idle(1); reset = 1'b0;
    rd(3'd0); rd(3'd4); rd(3'd5); rd(3'd6); rd(3'd7);

    // Random traffic, including simultaneous read+write
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = (a == 3'd5) ? 32'($urandom_range(0, 7)) : $urandom;
      bus(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
    end

    idle(3);
    @(negedge clk);
    #1;
    check("rd_q drained", 32'(rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
